// File: rtl/calc_pkg.sv
// calc_pkg: definitions shared by the calculator controller, the button
// encoder and the ALU.
//   - default widths and debounce length for calc_ctrl
//   - controller state enum
//   - 4-bit ALU operation codes
package calc_pkg;

  localparam int unsigned DataWDef    = 32;
  localparam int unsigned SwWDef      = 16;
  localparam int unsigned DbCyclesDef = 4;

  localparam int unsigned OpW = 4;

  typedef enum logic [1:0] {
    StIdle,
    StLatch,
    StExec,
    StWrite
  } state_e;

  // Operation codes understood by the ALU and produced by the encoder.
  localparam logic [OpW-1:0] OpAnd = 4'b0000;
  localparam logic [OpW-1:0] OpOr  = 4'b0001;
  localparam logic [OpW-1:0] OpAdd = 4'b0010;
  localparam logic [OpW-1:0] OpSub = 4'b0110;
  localparam logic [OpW-1:0] OpSlt = 4'b0111;
  localparam logic [OpW-1:0] OpNor = 4'b1100;

endpackage

// File: rtl/calc_debounce.sv
// calc_debounce: conditions the raw execute button.
//   clk      system clock
//   rst      asynchronous active-high reset
//   i_btn    raw button, asynchronous to clk
//   o_pulse  one-cycle pulse on each accepted 0->1 change of the button
// The button passes through a 2-flop synchronizer. A new level is accepted
// only after DB_CYCLES consecutive synchronized samples disagree with the
// current debounced level; any agreeing sample restarts the count.
module calc_debounce #(
  parameter int unsigned DB_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_btn,
  output logic o_pulse
);

  // The counter only needs to reach DB_CYCLES-1: the DB_CYCLES-th
  // disagreeing sample flips the level directly.
  localparam int unsigned CntW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(DB_CYCLES - 1);

  logic            r_sync1;
  logic            r_sync2;
  logic            r_level;
  logic            r_level_prev;
  logic [CntW-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1      <= 1'b0;
      r_sync2      <= 1'b0;
      r_level      <= 1'b0;
      r_level_prev <= 1'b0;
      r_cnt        <= '0;
    end else begin
      r_sync1      <= i_btn;
      r_sync2      <= r_sync1;
      r_level_prev <= r_level;
      if (r_sync2 != r_level) begin
        if (r_cnt == CntLast) begin
          r_level <= r_sync2;
          r_cnt   <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  // High in the first cycle the debounced level reads 1.
  assign o_pulse = r_level & ~r_level_prev;

endmodule

// File: rtl/calc_ctrl.sv
// calc_ctrl: sequencer between board buttons/switches and the calculator ALU.
//   clk         system clock
//   btnu        asynchronous active-high reset
//   btnd        raw execute button
//   op_in       operation code from the button encoder
//   sw          switch operand, sign-extended to DATA_W
//   alu_result  combinational ALU result
//   alu_ovf     ALU overflow flag
//   alu_zero    ALU zero flag
//   alu_op      op code to the ALU (held from LATCH to next LATCH)
//   alu_op1     accumulator snapshot taken in LATCH
//   alu_op2     sign-extended sw taken in LATCH
//   led         accumulator[15:0]
//   busy        high in LATCH, EXEC and WRITE
//   ovf_flag    overflow of the last completed execution
//   zero_flag   zero of the last completed execution
// An execute pulse in IDLE walks LATCH -> EXEC -> WRITE -> IDLE. Pulses
// arriving while busy are dropped. The accumulator takes the ALU result
// unmodified; the controller does no arithmetic of its own.
module calc_ctrl
  import calc_pkg::*;
#(
  parameter int unsigned DATA_W    = DataWDef,
  parameter int unsigned SW_W      = SwWDef,
  parameter int unsigned DB_CYCLES = DbCyclesDef
) (
  input  logic              clk,
  input  logic              btnu,
  input  logic              btnd,
  input  logic [OpW-1:0]    op_in,
  input  logic [SW_W-1:0]   sw,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_ovf,
  input  logic              alu_zero,
  output logic [OpW-1:0]    alu_op,
  output logic [DATA_W-1:0] alu_op1,
  output logic [DATA_W-1:0] alu_op2,
  output logic [15:0]       led,
  output logic              busy,
  output logic              ovf_flag,
  output logic              zero_flag
);

  logic              w_exec_pulse;
  logic [DATA_W-1:0] w_sw_ext;

  state_e            r_state;
  logic [DATA_W-1:0] r_acc;
  logic [OpW-1:0]    r_alu_op;
  logic [DATA_W-1:0] r_alu_op1;
  logic [DATA_W-1:0] r_alu_op2;
  logic              r_busy;
  logic              r_ovf;
  logic              r_zero;

  calc_debounce #(
    .DB_CYCLES (DB_CYCLES)
  ) u_debounce (
    .clk     (clk),
    .rst     (btnu),
    .i_btn   (btnd),
    .o_pulse (w_exec_pulse)
  );

  assign w_sw_ext = {{(DATA_W - SW_W){sw[SW_W-1]}}, sw};

  // busy is registered alongside the state so it changes on the same edge.
  always_ff @(posedge clk or posedge btnu) begin
    if (btnu) begin
      r_state   <= StIdle;
      r_acc     <= '0;
      r_alu_op  <= '0;
      r_alu_op1 <= '0;
      r_alu_op2 <= '0;
      r_busy    <= 1'b0;
      r_ovf     <= 1'b0;
      r_zero    <= 1'b0;
    end else begin
      case (r_state)
        StIdle: begin
          if (w_exec_pulse) begin
            r_state <= StLatch;
            r_busy  <= 1'b1;
          end
        end
        StLatch: begin
          r_alu_op  <= op_in;
          r_alu_op1 <= r_acc;
          r_alu_op2 <= w_sw_ext;
          r_state   <= StExec;
        end
        StExec: begin
          // Operands are stable for a full cycle while the ALU settles.
          r_state <= StWrite;
        end
        StWrite: begin
          r_acc   <= alu_result;
          r_ovf   <= alu_ovf;
          r_zero  <= alu_zero;
          r_busy  <= 1'b0;
          r_state <= StIdle;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= StIdle;
        end
      endcase
    end
  end

  assign alu_op    = r_alu_op;
  assign alu_op1   = r_alu_op1;
  assign alu_op2   = r_alu_op2;
  assign led       = r_acc[15:0];
  assign busy      = r_busy;
  assign ovf_flag  = r_ovf;
  assign zero_flag = r_zero;

endmodule

// File: tb/tb_calc_ctrl.sv
// Bench for calc_ctrl: a behavioural model (button -> accepted press ->
// three-cycle execution with its own ALU arithmetic) is compared against the
// main DUT every cycle; literal expectations pin the directed scenarios. A
// second instance with a one-sample debounce produces an execute pulse
// inside an execution to exercise the drop path.
module tb_calc_ctrl;
  import calc_pkg::*;

  localparam int unsigned DW  = 32;
  localparam int unsigned SWW = 16;
  localparam int unsigned DB  = 4;
  localparam logic [3:0] OpLoad = 4'b1111;  // bench ALU: result = op2
  localparam logic [3:0] OpSrl1 = 4'b1001;  // bench ALU: result = op1 >> 1

  logic          clk = 1'b0;
  logic          btnu, btnd;
  logic [3:0]    op_in;
  logic [15:0]   sw;
  logic [31:0]   alu_result;
  logic          alu_ovf, alu_zero;
  logic [3:0]    alu_op;
  logic [31:0]   alu_op1, alu_op2;
  logic [15:0]   led;
  logic          busy, ovf_flag, zero_flag;

  logic          d1_btnd;
  logic [3:0]    d1_op_in;
  logic [15:0]   d1_sw;
  logic [31:0]   d1_alu_result;
  logic          d1_alu_ovf, d1_alu_zero;
  logic [3:0]    d1_alu_op;
  logic [31:0]   d1_alu_op1, d1_alu_op2;
  logic [15:0]   d1_led;
  logic          d1_busy, d1_ovf_flag, d1_zero_flag;

  int n_cmp = 0;
  int n_bad = 0;
  int n_busy = 0;
  int n_busy1 = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  calc_ctrl #(.DATA_W(DW), .SW_W(SWW), .DB_CYCLES(DB)) dut (
    .clk(clk), .btnu(btnu), .btnd(btnd), .op_in(op_in), .sw(sw),
    .alu_result(alu_result), .alu_ovf(alu_ovf), .alu_zero(alu_zero),
    .alu_op(alu_op), .alu_op1(alu_op1), .alu_op2(alu_op2), .led(led),
    .busy(busy), .ovf_flag(ovf_flag), .zero_flag(zero_flag)
  );

  calc_ctrl #(.DATA_W(DW), .SW_W(SWW), .DB_CYCLES(1)) dut1 (
    .clk(clk), .btnu(btnu), .btnd(d1_btnd), .op_in(d1_op_in), .sw(d1_sw),
    .alu_result(d1_alu_result), .alu_ovf(d1_alu_ovf), .alu_zero(d1_alu_zero),
    .alu_op(d1_alu_op), .alu_op1(d1_alu_op1), .alu_op2(d1_alu_op2), .led(d1_led),
    .busy(d1_busy), .ovf_flag(d1_ovf_flag), .zero_flag(d1_zero_flag)
  );

  // Bench ALU.
  function automatic logic [31:0] alu_res(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    case (op)
      OpAnd:   return a & b;
      OpOr:    return a | b;
      OpAdd:   return a + b;
      OpSub:   return a - b;
      OpSlt:   return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      OpNor:   return ~(a | b);
      OpSrl1:  return a >> 1;
      default: return b;
    endcase
  endfunction

  function automatic logic alu_ov(input logic [3:0] op, input logic [31:0] a,
                                  input logic [31:0] b);
    logic [31:0] r;
    r = alu_res(op, a, b);
    if (op == OpAdd) return (a[31] == b[31]) && (r[31] != a[31]);
    if (op == OpSub) return (a[31] != b[31]) && (r[31] != a[31]);
    return 1'b0;
  endfunction

  always_comb begin
    alu_result    = alu_res(alu_op, alu_op1, alu_op2);
    alu_ovf       = alu_ov(alu_op, alu_op1, alu_op2);
    alu_zero      = (alu_result == 32'd0);
    d1_alu_result = alu_res(d1_alu_op, d1_alu_op1, d1_alu_op2);
    d1_alu_ovf    = alu_ov(d1_alu_op, d1_alu_op1, d1_alu_op2);
    d1_alu_zero   = (d1_alu_result == 32'd0);
  end

  // Behavioural model of the main DUT.
  logic        m_s1, m_s2, m_level, m_prev;
  int          m_run;
  int          m_rem;   // cycles of execution still to come, 0 = idle
  logic [3:0]  m_op;
  logic [31:0] m_op1, m_op2, m_acc;
  logic        m_ovf, m_zero;

  always @(posedge clk or posedge btnu) begin : model
    int          run_n;
    logic        lvl_n;
    logic [31:0] r;
    if (btnu) begin
      m_s1 <= 1'b0; m_s2 <= 1'b0; m_level <= 1'b0; m_prev <= 1'b0; m_run <= 0;
      m_rem <= 0; m_op <= '0; m_op1 <= '0; m_op2 <= '0; m_acc <= '0;
      m_ovf <= 1'b0; m_zero <= 1'b0;
    end else begin
      if (m_rem == 0) begin
        if (m_level && !m_prev) m_rem <= 3;
      end else if (m_rem == 3) begin
        m_op  <= op_in;
        m_op1 <= m_acc;
        m_op2 <= {{16{sw[15]}}, sw};
        m_rem <= 2;
      end else if (m_rem == 2) begin
        m_rem <= 1;
      end else begin
        r      = alu_res(m_op, m_op1, m_op2);
        m_acc  <= r;
        m_ovf  <= alu_ov(m_op, m_op1, m_op2);
        m_zero <= (r == 32'd0);
        m_rem  <= 0;
      end
      // A new level is accepted on the DB-th consecutive disagreeing sample.
      lvl_n = m_level;
      run_n = 0;
      if (m_s2 != m_level) begin
        run_n = m_run + 1;
        if (run_n == DB) begin
          lvl_n = m_s2;
          run_n = 0;
        end
      end
      m_prev  <= m_level;
      m_level <= lvl_n;
      m_run   <= run_n;
      m_s2    <= m_s1;
      m_s1    <= btnd;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (busy) n_busy++;
    if (d1_busy) n_busy1++;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", 32'(busy), 32'(m_rem != 0));
      check("alu_op", 32'(alu_op), 32'(m_op));
      check("alu_op1", alu_op1, m_op1);
      check("alu_op2", alu_op2, m_op2);
      check("led", 32'(led), 32'(m_acc[15:0]));
      check("ovf_flag", 32'(ovf_flag), 32'(m_ovf));
      check("zero_flag", 32'(zero_flag), 32'(m_zero));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic [3:0] op, input logic [15:0] s);
    op_in = op;
    sw    = s;
    btnd  = 1'b1;
    tick(12);
    btnd  = 1'b0;
    tick(10);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int b0;
    bit found;
    btnu = 1'b1; btnd = 1'b0; op_in = '0; sw = '0;
    d1_btnd = 1'b0; d1_op_in = OpAdd; d1_sw = 16'h0001;
    tick(3);
    @(negedge clk);
    check("rst_led", 32'(led), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_alu_op1", alu_op1, 32'h0);
    check("rst_flags", {30'd0, ovf_flag, zero_flag}, 32'h0);
    tick(1);
    btnu = 1'b0;
    chk_en = 1'b1;
    tick(2);

    // Basic add, then adding -3 returns to zero.
    b0 = n_busy;
    run_op(OpAdd, 16'h0003);
    @(negedge clk);
    check("add_led", 32'(led), 32'h0003);
    check("add_zero", 32'(zero_flag), 32'h0);
    check("add_busy_cycles", n_busy - b0, 3);
    check("add_model_acc", m_acc, 32'h0000_0003);
    run_op(OpAdd, 16'hFFFD);
    @(negedge clk);
    check("neg_led", 32'(led), 32'h0000);
    check("neg_zero", 32'(zero_flag), 32'h1);
    check("neg_op2", alu_op2, 32'hFFFF_FFFD);
    check("neg_op1", alu_op1, 32'h0000_0003);

    // Overflow: build 0x7FFFFFFF then add 1.
    run_op(OpLoad, 16'hFFFF);
    run_op(OpSrl1, 16'h0000);
    run_op(OpAdd, 16'h0001);
    @(negedge clk);
    check("ovf_led", 32'(led), 32'h0000);
    check("ovf_flag_set", 32'(ovf_flag), 32'h1);
    check("ovf_model_acc", m_acc, 32'h8000_0000);
    run_op(OpAdd, 16'h0001);
    @(negedge clk);
    check("ovf_clear", 32'(ovf_flag), 32'h0);
    check("ovf_next_led", 32'(led), 32'h0001);

    // Glitches shorter than the debounce window give nothing.
    tick(1);
    b0 = n_busy;
    op_in = OpAdd; sw = 16'h0001;
    for (int i = 0; i < 5; i++) begin
      btnd = 1'b1; tick(2);
      btnd = 1'b0; tick(2);
    end
    tick(10);
    check("glitch_busy", n_busy - b0, 0);
    check("glitch_led", 32'(led), 32'h0001);
    btnd = 1'b1; tick(50);
    btnd = 1'b0; tick(10);
    check("hold_busy", n_busy - b0, 3);
    check("hold_led", 32'(led), 32'h0002);

    // Reset during EXEC.
    run_op(OpLoad, 16'h0005);
    check("preload_led", 32'(led), 32'h0005);
    op_in = OpAdd; sw = 16'h0007; btnd = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      tick(1);
      if (m_rem == 2) found = 1'b1;
    end
    check("reach_exec", 32'(found), 32'h1);
    btnu = 1'b1; btnd = 1'b0;
    @(negedge clk);
    check("mid_rst_busy", 32'(busy), 32'h0);
    check("mid_rst_led", 32'(led), 32'h0);
    check("mid_rst_ops", {alu_op, alu_op1[27:0]} | alu_op2, 32'h0);
    tick(2);
    btnu = 1'b0;
    b0 = n_busy;
    tick(15);
    check("post_rst_led", 32'(led), 32'h0);
    check("post_rst_busy", n_busy - b0, 0);

    // Drop path on the one-sample-debounce instance.
    b0 = n_busy1;
    d1_btnd = 1'b1; tick(1);
    d1_btnd = 1'b0; tick(1);
    d1_btnd = 1'b1; tick(1);
    d1_btnd = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (d1_busy) found = 1'b1;
    end
    check("d1_busy_seen", 32'(found), 32'h1);
    @(posedge clk);
    #1;
    d1_op_in = OpSub;
    @(negedge clk);
    check("d1_op_held", 32'(d1_alu_op), 32'(OpAdd));
    tick(15);
    check("d1_led", 32'(d1_led), 32'h0001);
    check("d1_busy_cycles", n_busy1 - b0, 3);

    // Randomized presses, glitches, mid-press input changes and resets.
    for (int k = 0; k < 60; k++) begin
      int hold;
      hold  = int'($urandom_range(1, 14));
      op_in = 4'($urandom_range(0, 15));
      sw    = 16'($urandom);
      btnd  = 1'b1;
      tick(hold / 2 + 1);
      if ($urandom_range(0, 3) == 0) begin
        op_in = 4'($urandom_range(0, 15));
        sw    = 16'($urandom);
      end
      tick(hold - hold / 2);
      btnd = 1'b0;
      if ($urandom_range(0, 19) == 0) begin
        btnu = 1'b1;
        tick(1);
        btnu = 1'b0;
      end
      tick(int'($urandom_range(1, 12)));
    end
    tick(20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
